// File: rtl/multiport_regfile.sv
// Operand register file: one write port, NUM_RD registered read ports, per-entry
// written tracking and a sequential clear engine. MPRF_BYPASS_EN forwards same-cycle writes to reads.

module multiport_regfile_rd_port #(
  parameter int DATA_WIDTH = 66
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  word_uninit,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  uninit
);
  // A disabled port holds its last data/uninit; only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      valid  <= 1'b0;
      uninit <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        data   <= word;
        uninit <= word_uninit;
      end
    end
  end
endmodule

module multiport_regfile #(
  parameter int DATA_WIDTH = 66,
  parameter int DEPTH      = 4,
  parameter int NUM_RD     = 2,
  localparam int ADDR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_req,
  output logic                         busy,
  input  logic                         w_en,
  input  logic [ADDR_W-1:0]            w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [NUM_RD-1:0]            r_en,
  input  logic [NUM_RD*ADDR_W-1:0]     r_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
  output logic [NUM_RD-1:0]            r_valid,
  output logic [NUM_RD-1:0]            r_uninit
);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                             state, state_nxt;
  logic [ADDR_W-1:0]                  idx, idx_nxt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   mem;
  logic [DEPTH-1:0]                   wr;
  logic                               w_acc;
  logic [NUM_RD-1:0]                  rd_en;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_word, rd_data;
  logic [NUM_RD-1:0]                  rd_uninit;

  assign busy  = (state == CLEAR);
  assign w_acc = (state == IDLE) && w_en && ({1'b0, w_addr} < DEPTH_C);
  assign rd_en = r_en & {NUM_RD{state == IDLE}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (clr_req) begin
        state_nxt = CLEAR;
        idx_nxt   = '0;
      end
      CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data array is not reset; the written bits alone define initialisation.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[idx] <= '0;
    else if (w_acc)     mem[w_addr] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wr <= '0;
    else if (state == CLEAR) wr[idx] <= 1'b0;
    else if (w_acc)          wr[w_addr] <= 1'b1;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = r_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_word[i]   = '0;
      rd_uninit[i] = 1'b1;
      if ({1'b0, a} < DEPTH_C) begin
        rd_word[i]   = mem[a];
        rd_uninit[i] = ~wr[a];
`ifdef MPRF_BYPASS_EN
        if (w_acc && (w_addr == a)) begin
          rd_word[i]   = w_data;
          rd_uninit[i] = 1'b0;
        end
`endif
      end
    end

    multiport_regfile_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk         (clk),
      .rst         (rst),
      .en          (rd_en[i]),
      .word        (rd_word[i]),
      .word_uninit (rd_uninit[i]),
      .data        (rd_data[i]),
      .valid       (r_valid[i]),
      .uninit      (r_uninit[i])
    );
  end

  assign r_data = rd_data;
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed plus randomized bench for multiport_regfile against an array-based
// reference model (DEPTH=6 so addresses 6..7 exercise the out-of-range path).

module tb_multiport_regfile;
  localparam int DW = 66;
  localparam int D  = 6;
  localparam int NR = 3;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst, clr_req, busy, w_en;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [NR-1:0]    r_en, r_valid, r_uninit;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;

  multiport_regfile #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .r_valid(r_valid), .r_uninit(r_uninit)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays plus a count of remaining clear cycles.
  logic [DW-1:0] mem_m [D];
  bit            wr_m  [D];
  int            clr_left;
  logic [DW-1:0] exp_d [NR];
  bit            exp_u [NR];
  bit            exp_v [NR];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input int port, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s port %0d observed %h expected %h", tag, port, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < D; k++) wr_m[k] = 1'b0;
    clr_left = 0;
    for (int i = 0; i < NR; i++) begin
      exp_d[i] = '0; exp_u[i] = 1'b0; exp_v[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("busy", 0, DW'(busy), DW'(clr_left > 0));
    for (int i = 0; i < NR; i++) begin
      chk("r_valid", i, DW'(r_valid[i]), DW'(exp_v[i]));
      chk("r_uninit", i, DW'(r_uninit[i]), DW'(exp_u[i]));
      if (!$isunknown(exp_d[i])) chk("r_data", i, r_data[i*DW +: DW], exp_d[i]);
    end
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic cycle();
    if (rst) model_reset();
    else if (clr_left > 0) begin
      mem_m[D-clr_left] = '0;
      wr_m[D-clr_left]  = 1'b0;
      clr_left--;
      for (int i = 0; i < NR; i++) exp_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        int a;
        a = int'(r_addr[i*AW +: AW]);
        exp_v[i] = r_en[i];
        if (r_en[i]) begin
          if (a < D) begin
            exp_d[i] = mem_m[a];
            exp_u[i] = !wr_m[a];
`ifdef MPRF_BYPASS_EN
            if (w_en && int'(w_addr) == a) begin
              exp_d[i] = w_data;
              exp_u[i] = 1'b0;
            end
`endif
          end else begin
            exp_d[i] = '0;
            exp_u[i] = 1'b1;
          end
        end
      end
      if (w_en && int'(w_addr) < D) begin
        mem_m[w_addr] = w_data;
        wr_m[w_addr]  = 1'b1;
      end
      if (clr_req) clr_left = D;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic setr(input int i, input bit en, input int a);
    r_en[i] = en;
    r_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic idle_in();
    clr_req = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; r_en = '0; r_addr = '0;
  endtask

  task automatic wr_in(input int a, input logic [DW-1:0] d);
    w_en = 1'b1; w_addr = AW'(a); w_data = d;
  endtask

  initial begin
    for (int k = 0; k < D; k++) mem_m[k] = 'x;
    model_reset();
    rst = 1'b1;
    idle_in();
    cycle(); cycle();
    rst = 1'b0;

    // Never-written entry on every port.
    for (int i = 0; i < NR; i++) setr(i, 1'b1, 3);
    cycle();
    chk("uninit_all", 0, DW'(r_uninit), DW'({NR{1'b1}}));

    // Write then read on the next cycle.
    idle_in(); wr_in(1, DW'(8'h2A)); cycle();
    idle_in(); setr(0, 1'b1, 1); cycle();
    chk("rd_after_wr", 0, r_data[DW-1:0], DW'(8'h2A));

    // Same-cycle read/write of one address.
    idle_in(); wr_in(2, DW'(8'h11)); cycle();
    idle_in(); wr_in(2, DW'(8'h55)); setr(1, 1'b1, 2); cycle();

    // Port 0 alone, then an idle cycle: other ports untouched.
    idle_in(); setr(0, 1'b1, 2); setr(2, 1'b1, 7); cycle();
    idle_in(); setr(0, 1'b1, 1); cycle();
    idle_in(); cycle();

    // Clear with a coincident write, writes/reads ignored while busy.
    idle_in(); clr_req = 1'b1; wr_in(4, DW'(8'h77)); cycle();
    for (int c = 0; c < D; c++) begin
      idle_in(); clr_req = 1'b1; wr_in(c, DW'(c + 9)); r_en = '1; cycle();
    end
    for (int a = 0; a < 8; a++) begin
      idle_in();
      for (int i = 0; i < NR; i++) setr(i, 1'b1, a);
      cycle();
    end

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      clr_req = ($urandom_range(0, 40) == 0);
      w_en    = $urandom_range(0, 1) == 1;
      w_addr  = AW'($urandom_range(0, 7));
      w_data  = {2'($urandom), $urandom, $urandom};
      for (int i = 0; i < NR; i++) setr(i, $urandom_range(0, 2) != 0, $urandom_range(0, 7));
      cycle();
    end

    // Reset in the second cycle of a clear.
    idle_in(); while (clr_left > 0) cycle();
    clr_req = 1'b1; r_en = '1; cycle();
    idle_in(); cycle();
    rst = 1'b1; #1;
    model_reset();
    check_outputs();
    chk("rst_data", 0, DW'(r_data != '0), DW'(0));
    cycle();
    rst = 1'b0;
    for (int a = 0; a < D; a++) begin
      idle_in();
      for (int i = 0; i < NR; i++) setr(i, 1'b1, a);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised register file with one write port and NUM_RD independent registered read ports. It generalises the fixed 4-entry, 2-read-port memory to configurable depth, width and port count. It adds per-entry written/valid tracking, a per-port read-valid strobe, and a sequential clear engine. It sits between the issue stage and the execution datapath as the operand store.

## Interface

Parameters:
- DATA_WIDTH, default 66: entry width in bits; the default equals 2*(32+1).
- DEPTH, default 4: number of entries; must be ≥ 2, need not be a power of two.
- NUM_RD, default 2: number of read ports; must be ≥ 1.
- ADDR_W is a derived localparam: max(1, clog2(DEPTH)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  request to clear the whole array.
- busy  out  1  clear engine active.
- w_en  in  1  write enable.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_WIDTH  write data.
- r_en  in  NUM_RD  per-port read enable.
- r_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- r_data  out  NUM_RD*DATA_WIDTH  packed registered read data.
- r_valid  out  NUM_RD  per-port strobe: r_data for that port was updated this cycle.
- r_uninit  out  NUM_RD  per-port flag: the returned entry had not been written since the last reset or clear.

## Operation

- State per entry: data word mem[k] and written bit wr[k].
- Reset does not clear mem; it clears all wr bits.
- Two-state FSM:
  - IDLE: normal operation.
    - clr_req=1 → CLEAR, with index cleared to 0.
  - CLEAR: each cycle writes mem[index]=0 and wr[index]=0, then increments index.
    - After index DEPTH-1 is cleared → IDLE.
    - clr_req is ignored while in CLEAR.
- Write (IDLE only): when w_en=1 and w_addr<DEPTH, set mem[w_addr]=w_data and wr[w_addr]=1.
  - A write to w_addr≥DEPTH is dropped silently.
  - w_en is ignored in CLEAR.
- Read port i (IDLE only): when r_en[i]=1, on the next edge:
  - r_data_i gets mem[r_addr_i];
  - r_uninit[i] gets !wr[r_addr_i];
  - r_valid[i] goes to 1.
  - Out-of-range address: r_data_i=0, r_uninit[i]=1, r_valid[i]=1.
- Port with r_en[i]=0, or any port in CLEAR: r_data_i and r_uninit[i] hold their values; r_valid[i]=0.
- Ports are fully independent. A disabled port never zeroes or otherwise disturbs another port.
- Same-cycle read and write to the same address: the read returns the old contents (read-before-write), unless the bypass option is enabled (see Configuration).
- Multiple ports may read the same address in one cycle; all of them receive identical data.

## Timing

- Read latency: 1 cycle from the r_en sample to r_data/r_valid.
- Write is visible to reads sampled one or more cycles later.
- busy:
  - Rises the cycle after clr_req is sampled in IDLE.
  - Stays high exactly DEPTH cycles.
  - The first cycle with busy=0 accepts reads and writes.
- clr_req and w_en in the same IDLE cycle: the write commits, then the clear wipes it.
- Reset values: busy=0, r_data=0, r_valid=0, r_uninit=0, FSM=IDLE, index=0, all wr=0.
- Reset asserted mid-clear: immediate return to IDLE. The mem contents are then partially cleared, which is acceptable because all wr=0.

## Configuration

- Macro: MPRF_BYPASS_EN.
- Defined: a read of address A in the same cycle as an accepted write to A returns w_data with r_uninit=0.
- Undefined: that read returns the pre-write mem[A] and the pre-write !wr[A].
- No effect in CLEAR, because neither reads nor writes are accepted there.

## Test plan

- Reset, then write A=1 with 0x2A and read A=1 on port 0 the next cycle → r_data0=0x2A, r_valid0=1, r_uninit0=0.
- After reset, read A=3 on all ports with no prior write → r_uninit=all ones, r_valid=all ones.
- Write A=2 with 0x55 and, in the same cycle, read A=2 on port 1 (old value 0x11):
  - without MPRF_BYPASS_EN → r_data1=0x11;
  - with MPRF_BYPASS_EN → r_data1=0x55, r_uninit1=0.
- Read on port 0 only, followed by an idle cycle → port 1 r_data unchanged and r_valid1=0; port 0 holds with r_valid0=0 in the idle cycle.
- Pulse clr_req with DEPTH=4 → busy high for 4 cycles; w_en during busy is dropped; afterwards every read returns 0 with r_uninit=1.
- Assert rst during cycle 2 of a clear → busy=0 and all outputs zero on the same cycle; a subsequent read returns r_uninit=1.
